// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised SPI master: width, divider, bit order, CPOL/CPHA, chip selects
module spi_master_param #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int NUM_CS    = 1,
    parameter int LSB_FIRST = 0,
    localparam int CSW      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_cpol,
    input  logic              i_cpha,
    input  logic [CSW-1:0]    i_cs_sel,
    output logic              o_sclk,
    output logic              o_mosi,
    input  logic              i_miso,
    output logic [NUM_CS-1:0] o_cs_n,
    output logic              o_rx_valid,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_busy
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HALF_W = $clog2(2 * DATA_W);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DIV_W-1:0]    r_div;
    logic [HALF_W-1:0]   r_half;
    logic                r_cpha;
    logic                r_sclk;
    logic                r_mosi;
    logic [DATA_W-1:0]   r_tx_shift;
    logic [DATA_W-1:0]   r_rx_shift;
    logic [NUM_CS-1:0]   r_cs_n;
    logic                r_rx_valid;
    logic [DATA_W-1:0]   r_rx_data;
    logic [NUM_CS-1:0]   w_cs_dec;

    // Next bit to put on the line, given the remaining transmit word
    function automatic logic out_bit(input logic [DATA_W-1:0] d);
        return (LSB_FIRST != 0) ? d[0] : d[DATA_W-1];
    endfunction

    // Drop the bit just driven from the transmit word
    function automatic logic [DATA_W-1:0] tx_advance(input logic [DATA_W-1:0] d);
        return (LSB_FIRST != 0) ? (d >> 1) : (d << 1);
    endfunction

    // Insert a received bit so that the first bit on the wire lands at the correct end
    function automatic logic [DATA_W-1:0] rx_insert(input logic [DATA_W-1:0] d, input logic b);
        return (LSB_FIRST != 0) ? {b, d[DATA_W-1:1]} : {d[DATA_W-2:0], b};
    endfunction

    logic w_accept;
    logic w_div_done;
    logic w_edge;
    logic w_leading;
    logic w_trailing;
    logic w_last_half;
    logic w_shift_out;
    logic w_sample;
    logic w_done;

    assign w_accept    = i_tx_valid && (r_state == S_IDLE);
    assign w_div_done  = (r_div == DIV_LAST);
    assign w_edge      = (r_state == S_XFER) && w_div_done;
    assign w_leading   = w_edge && !r_half[0];
    assign w_trailing  = w_edge && r_half[0];
    assign w_last_half = (r_half == HALF_LAST);
    // cpha=0 pre-loads the first bit at accept, so it never shifts after the final bit
    assign w_shift_out = r_cpha ? w_leading : (w_trailing && !w_last_half);
    assign w_sample    = r_cpha ? w_trailing : w_leading;
    assign w_done      = (r_state == S_HOLD) && w_div_done;

    // Chip-select decode; an out-of-range selector leaves every line deasserted
    always_comb begin
        w_cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (i_cs_sel == CSW'(i)) begin
                w_cs_dec[i] = 1'b0;
            end
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: each phase ends on a divider wrap
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_SETUP;
            S_SETUP: if (w_div_done) w_next = S_XFER;
            S_XFER:  if (w_div_done && w_last_half) w_next = S_HOLD;
            S_HOLD:  if (w_div_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM outputs: handshake and busy flag
    always_comb begin
        o_tx_ready = (r_state == S_IDLE);
        o_busy     = (r_state != S_IDLE);
    end

    // Half-period divider and half-period index within XFER
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div  <= '0;
            r_half <= '0;
        end else if (w_accept) begin
            r_div  <= '0;
            r_half <= '0;
        end else if (r_state != S_IDLE) begin
            r_div <= w_div_done ? '0 : r_div + 1'b1;
            if (w_edge) begin
                r_half <= r_half + 1'b1;
            end
        end
    end

    // Serial clock and shift registers for both directions
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cpha     <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
        end else if (w_accept) begin
            r_cpha     <= i_cpha;
            r_sclk     <= i_cpol;
            r_rx_shift <= '0;
            if (i_cpha) begin
                r_tx_shift <= i_tx_data;
            end else begin
                r_mosi     <= out_bit(i_tx_data);
                r_tx_shift <= tx_advance(i_tx_data);
            end
        end else begin
            if (w_edge) begin
                r_sclk <= !r_sclk;
            end
            if (w_shift_out) begin
                r_mosi     <= out_bit(r_tx_shift);
                r_tx_shift <= tx_advance(r_tx_shift);
            end
            if (w_sample) begin
                r_rx_shift <= rx_insert(r_rx_shift, i_miso);
            end
        end
    end

    // Chip selects and the completion pulse with the received word
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cs_n     <= '1;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_accept) begin
                r_cs_n <= w_cs_dec;
            end else if (w_done) begin
                r_cs_n     <= '1;
                r_rx_valid <= 1'b1;
                r_rx_data  <= r_rx_shift;
            end
        end
    end

    assign o_sclk     = r_sclk;
    assign o_mosi     = r_mosi;
    assign o_cs_n     = r_cs_n;
    assign o_rx_valid = r_rx_valid;
    assign o_rx_data  = r_rx_data;

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised SPI master, the successor to the fixed 8-bit, mode-0 SPI controller. It adds configurable word width, SCLK divider, bit order, all four CPOL/CPHA modes selected per transfer, and multiple chip selects. A valid/ready transmit port and a one-cycle rx_valid result port connect it to the system side; SCLK/MOSI/MISO/cs_n go to the pads or to a loopback SPI slave.

Parameters:
DATA_W, 8, bits per transfer (2..32)
CLK_DIV, 4, clk cycles per SCLK half-period (>=1)
NUM_CS, 1, number of chip-select lines (1..8)
LSB_FIRST, 0, 0 = MSB shifted first, 1 = LSB shifted first
CSW, derived, (NUM_CS>1) ? $clog2(NUM_CS) : 1

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  asynchronous, active-low reset
tx_valid  in  1  transfer request
tx_ready  out  1  high only in IDLE
tx_data  in  DATA_W  word to send
cpol  in  1  SCLK idle level; sampled at accept
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled at accept
cs_sel  in  CSW  target slave; sampled at accept
sclk  out  1  serial clock
mosi  out  1  serial data out
miso  in  1  serial data in
cs_n  out  NUM_CS  active-low chip selects, one-hot-low
rx_valid  out  1  one-cycle pulse, rx_data valid
rx_data  out  DATA_W  received word, held until next rx_valid
busy  out  1  high in SETUP/XFER/HOLD

Behaviour:
- Reset (rst=0, async): state IDLE; sclk=0; mosi=0; cs_n=all 1; rx_valid=0; rx_data=0; busy=0; tx_ready=1 after release; counters and shift registers cleared. Reset mid-transfer aborts immediately; no rx_valid is produced.
- Accept: tx_valid & tx_ready at posedge (cycle 0) latches tx_data, cpol, cpha, cs_sel; the FSM enters SETUP at cycle 1. tx_data is ignored outside IDLE.
- FSM: IDLE -> SETUP (CLK_DIV cycles) -> XFER (2*DATA_W half-periods of CLK_DIV cycles each) -> HOLD (CLK_DIV cycles) -> IDLE.
- SETUP: cs_n[cs_sel]=0 from cycle 1. sclk=cpol. With cpha=0, mosi holds the first bit from cycle 1. If cs_sel>=NUM_CS, the transfer runs with no cs_n asserted.
- XFER: sclk toggles at the end of every half-period, giving exactly 2*DATA_W edges. The leading edge is the first edge of each bit pair; the trailing edge is the second.
  - cpha=0: miso is sampled on the leading edge; mosi advances on the trailing edge, except after the last bit.
  - cpha=1: mosi advances on the leading edge (first bit is driven at the first leading edge); miso is sampled on the trailing edge.
- After the final edge, sclk=cpol.
- Bit order: LSB_FIRST selects the shift direction for both mosi and rx assembly.
- HOLD: cs_n stays low for CLK_DIV cycles, then all cs_n go to 1.
- Completion: in the same cycle cs_n deasserts, rx_valid=1 for one cycle, rx_data is updated, state is IDLE, and tx_ready=1. A new accept is possible in that cycle.
- Latency: rx_valid is asserted exactly N = CLK_DIV*(2*DATA_W+2)+1 cycles after the accept edge.
- mosi keeps its last value in IDLE. busy = ~tx_ready.
- Back-to-back: if tx_valid is held high, the next accept occurs in the rx_valid cycle. cs_n is high for at least one cycle between transfers.

Test Plan:
1. DATA_W=8, CLK_DIV=2, mode 0, miso looped to mosi, tx_data=0xA5 -> rx_valid at cycle 37 after accept, rx_data=0xA5; sclk shows 16 edges and idles low; cs_n[0] low for cycles 1..36.
2. Modes 1/2/3 with loopback, tx_data=0x3C -> rx_data=0x3C each time; sclk idles at cpol; a checker on mosi confirms it is stable for a full half-period around every sample edge.
3. NUM_CS=4, cs_sel=2, miso driven by a slave model returning 0x5A, tx_data=0xFF -> only cs_n[2] toggles, rx_data=0x5A. Repeat with cs_sel beyond NUM_CS-1 (NUM_CS=3, cs_sel=3) -> no cs_n asserted, rx_valid still at cycle N.
4. DATA_W=12, LSB_FIRST=1, CLK_DIV=1, tx_data=0x801 -> first mosi bit=1, second=0, last=1; rx_data=0x801 in loopback; N=27.
5. tx_valid held high for 3 words (0x11, 0x22, 0x33) -> three rx_valid pulses spaced exactly N cycles apart; cs_n high for at least one cycle between words.
6. Assert rst low at the 5th sclk edge -> cs_n=all 1, sclk=0, busy=0 immediately; no rx_valid; the next transfer after release completes correctly.
